// File: rtl/ff_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ff_pkg
//  Purpose  : Shared mode encodings and per-bit next-state function for the
//             multimode flip-flop register.
//  Revision : 1.0  initial release
// ============================================================================
package ff_pkg;

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  // Next value of one bit plus a flag for an illegal S=R=1 request.
  typedef struct packed {
    logic conflict;
    logic nxt;
  } ff_next_t;

  function automatic ff_next_t ff_next(input logic [1:0] mode,
                                       input logic       j,
                                       input logic       k,
                                       input logic       q);
    ff_next_t r;
    r.nxt      = q;
    r.conflict = 1'b0;
    case (mode)
      MODE_JK: begin
        case ({j, k})
          2'b01:   r.nxt = 1'b0;
          2'b10:   r.nxt = 1'b1;
          2'b11:   r.nxt = ~q;
          default: r.nxt = q;
        endcase
      end
      MODE_D:  r.nxt = j;
      MODE_T:  r.nxt = q ^ j;
      default: begin
        // SR: an S=R=1 request leaves the bit untouched and is reported.
        case ({j, k})
          2'b10:   r.nxt = 1'b1;
          2'b01:   r.nxt = 1'b0;
          2'b11:   r.conflict = 1'b1;
          default: r.nxt = q;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage : ff_pkg
`default_nettype wire

// File: rtl/ff_next_bit.sv
`default_nettype none
// ============================================================================
//  Module   : ff_next_bit
//  Purpose  : Combinational next-state slice for a single register bit.
//  Revision : 1.0  initial release
// ============================================================================
module ff_next_bit
  import ff_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic       j_i,
  input  logic       k_i,
  input  logic       q_i,
  output logic       q_next_o,
  output logic       conflict_o
);

  ff_next_t res;

  // Evaluate the shared per-bit rule for the currently sampled mode.
  always_comb begin
    res        = ff_next(mode_i, j_i, k_i, q_i);
    q_next_o   = res.nxt;
    conflict_o = res.conflict;
  end

endmodule : ff_next_bit
`default_nettype wire

// File: rtl/multimode_ff_reg.sv
`default_nettype none
// ============================================================================
//  Module   : multimode_ff_reg
//  Purpose  : N-bit register with run-time JK/D/T/SR mode, clock enable,
//             synchronous clear, registered complement, change strobe and
//             sticky SR-conflict flag.
//  Revision : 1.0  initial release
// ============================================================================
module multimode_ff_reg
  import ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             EN,
  input  logic             CLR,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             CHG,
  output logic             SR_ERR
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qn_q, qn_d;
  logic             chg_q, chg_d;
  logic             sr_err_q, sr_err_d;
  logic [WIDTH-1:0] mode_next;
  logic [WIDTH-1:0] bit_conflict;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      ff_next_bit u_next (
        .mode_i     (MODE),
        .j_i        (J[gi]),
        .k_i        (K[gi]),
        .q_i        (q_q[gi]),
        .q_next_o   (mode_next[gi]),
        .conflict_o (bit_conflict[gi])
      );
    end
  endgenerate

  // Select next state with CLR over EN over hold; Qn comes from the same value.
  always_comb begin
    q_d      = q_q;
    chg_d    = 1'b0;
    sr_err_d = sr_err_q;
    if (CLR) begin
      q_d      = RST_VAL;
      chg_d    = (q_q != RST_VAL);
      sr_err_d = 1'b0;
    end else if (EN) begin
      q_d      = mode_next;
      chg_d    = (mode_next != q_q);
      sr_err_d = sr_err_q | ((MODE == MODE_SR) & (|bit_conflict));
    end
    qn_d = ~q_d;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      q_q      <= RST_VAL;
      qn_q     <= ~RST_VAL;
      chg_q    <= 1'b0;
      sr_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      qn_q     <= qn_d;
      chg_q    <= chg_d;
      sr_err_q <= sr_err_d;
    end
  end

  assign Q      = q_q;
  assign Qn     = qn_q;
  assign CHG    = chg_q;
  assign SR_ERR = sr_err_q;

endmodule : multimode_ff_reg
`default_nettype wire

// File: tb/tb_multimode_ff_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multimode_ff_reg
//  Purpose  : Self-checking bench for multimode_ff_reg (WIDTH=8, RST_VAL=A5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_multimode_ff_reg;

  localparam logic [7:0] RV = 8'hA5;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic [7:0] J = '0;
  logic [7:0] K = '0;
  logic [7:0] Q, Qn;
  logic       CHG, SR_ERR;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] q;
    logic       chg;
    logic       err;
  } exp_t;

  exp_t sb[$];

  // Reference state, advanced once per driven edge.
  logic [7:0] m_q   = RV;
  logic       m_chg = 1'b0;
  logic       m_err = 1'b0;

  always #5 CLK = ~CLK;

  multimode_ff_reg #(.WIDTH(8), .RST_VAL(RV)) dut (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .CLR(CLR), .MODE(MODE),
    .J(J), .K(K), .Q(Q), .Qn(Qn), .CHG(CHG), .SR_ERR(SR_ERR)
  );

  task automatic cmp(input string name, input logic [7:0] q, input logic chg, input logic err);
    total++;
    if (Q !== q || Qn !== ~q || CHG !== chg || SR_ERR !== err) begin
      bad++;
      $display("FAIL %s: got Q=%h Qn=%h CHG=%b SR_ERR=%b want Q=%h Qn=%h CHG=%b SR_ERR=%b",
               name, Q, Qn, CHG, SR_ERR, q, ~q, chg, err);
    end
  endtask

  // Characteristic equations written from the mode truth tables.
  function automatic logic [7:0] model_next(input logic [1:0] mode, input logic [7:0] j,
                                            input logic [7:0] k, input logic [7:0] q);
    case (mode)
      2'd0:    return (j & ~q) | (~k & q);
      2'd1:    return j;
      2'd2:    return q ^ j;
      default: return (j & ~k) | (q & ~(j ^ k)) | (q & j & k);
    endcase
  endfunction

  // Drive one edge's inputs and queue the expected post-edge state.
  task automatic step(input logic en, input logic clr, input logic [1:0] mode,
                      input logic [7:0] j, input logic [7:0] k);
    logic [7:0] nq;
    @(negedge CLK);
    EN = en; CLR = clr; MODE = mode; J = j; K = k;
    if (clr) begin
      m_chg = (m_q != RV);
      m_q   = RV;
      m_err = 1'b0;
    end else if (en) begin
      nq    = model_next(mode, j, k, m_q);
      m_chg = (nq != m_q);
      m_q   = nq;
      if (mode == 2'd3 && (j & k) != 8'h00) m_err = 1'b1;
    end else begin
      m_chg = 1'b0;
    end
    sb.push_back('{q: m_q, chg: m_chg, err: m_err});
  endtask

  // Directed check against a literal value right after the pending edge.
  task automatic expect_after(input string name, input logic [7:0] q, input logic chg, input logic err);
    @(posedge CLK);
    #2;
    cmp(name, q, chg, err);
  endtask

  // Scoreboard monitor: pop one expectation per edge that has one queued.
  always begin
    exp_t e;
    @(posedge CLK);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("scoreboard", e.q, e.chg, e.err);
    end
  end

  // Complement invariant sampled mid-cycle, including under reset.
  always begin
    @(negedge CLK);
    total++;
    if (Qn !== ~Q) begin
      bad++;
      $display("FAIL qn_invariant: got Q=%h Qn=%h want Qn=%h", Q, Qn, ~Q);
    end
  end

  initial begin
    // Power-on reset.
    repeat (2) @(posedge CLK);
    #2;
    cmp("reset_state", RV, 1'b0, 1'b0);
    @(negedge CLK);
    RST_n = 1'b1;

    // Asynchronous reset between edges.
    step(1, 0, 2'd1, 8'h3C, 8'h00);
    expect_after("load_3C", 8'h3C, 1'b1, 1'b0);
    #1 RST_n = 1'b0;
    #1 cmp("reset_mid_run", RV, 1'b0, 1'b0);
    RST_n = 1'b1;
    m_q = RV; m_chg = 1'b0; m_err = 1'b0;

    // JK mode from zero.
    step(1, 0, 2'd1, 8'h00, 8'h00);
    expect_after("load_00", 8'h00, 1'b1, 1'b0);
    step(1, 0, 2'd0, 8'hF0, 8'h0F);
    expect_after("jk_set_reset", 8'hF0, 1'b1, 1'b0);
    step(1, 0, 2'd0, 8'hFF, 8'hFF);
    expect_after("jk_toggle", 8'h0F, 1'b1, 1'b0);
    step(1, 0, 2'd0, 8'h00, 8'h00);
    expect_after("jk_hold", 8'h0F, 1'b0, 1'b0);

    // D and T modes, then enable low.
    step(1, 0, 2'd1, 8'h5A, 8'h00);
    expect_after("d_load", 8'h5A, 1'b1, 1'b0);
    step(1, 0, 2'd2, 8'h0F, 8'hFF);
    expect_after("t_toggle", 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'd1, 8'hFF, 8'hFF);
      expect_after("en_low_hold", 8'h55, 1'b0, 1'b0);
    end

    // SR conflict and stickiness.
    step(1, 0, 2'd1, 8'h00, 8'h00);
    expect_after("load_00b", 8'h00, 1'b1, 1'b0);
    step(1, 0, 2'd3, 8'h81, 8'h01);
    expect_after("sr_conflict", 8'h80, 1'b1, 1'b1);
    step(1, 0, 2'd3, 8'h02, 8'h00);
    expect_after("sr_sticky_set", 8'h82, 1'b1, 1'b1);
    step(1, 0, 2'd3, 8'h00, 8'h02);
    expect_after("sr_sticky_reset", 8'h80, 1'b1, 1'b1);

    // CLR wins over EN and a simultaneous conflict.
    step(1, 1, 2'd3, 8'hFF, 8'hFF);
    expect_after("clr_priority", RV, 1'b1, 1'b0);
    step(1, 1, 2'd3, 8'hFF, 8'hFF);
    expect_after("clr_again", RV, 1'b0, 1'b0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end

    repeat (3) @(posedge CLK);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multimode_ff_reg
`default_nettype wire
